// File: rtl/seq_runner.sv
// Bit-serial pattern runner: feeds up to W pattern bits (LSB first) through a 2-bit core state machine and counts visits to state 11.
// Optional macro SEQ_RUNNER_HIT_EN adds hit/first_hit outputs reporting the first bit index that reached state 11.
module seq_runner #(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [CW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
`ifdef SEQ_RUNNER_HIT_EN
    output logic          hit,
    output logic [CW-1:0] first_hit,
`endif
    output logic [1:0]    final_q
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CW-1:0] WMAX = CW'(W);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t        state, state_nxt;
    logic [W-1:0]  sh;
    logic [CW-1:0] rem;
    logic [CW-1:0] cnt;
    logic [1:0]    q;
    logic [1:0]    q_nxt;
    logic [CW-1:0] len_c;
`ifdef SEQ_RUNNER_HIT_EN
    logic [CW-1:0] idx;
    logic          hit_r;
    logic [CW-1:0] fh_r;
`endif

    function automatic logic [1:0] core_next(input logic [1:0] s, input logic a);
        logic [1:0] r;
        if (a) begin
            case (s)
                2'b00:   r = 2'b11;
                2'b01:   r = 2'b00;
                2'b10:   r = 2'b00;
                default: r = 2'b01;
            endcase
        end else begin
            case (s)
                2'b00:   r = 2'b10;
                2'b01:   r = 2'b01;
                2'b10:   r = 2'b11;
                default: r = 2'b10;
            endcase
        end
        return r;
    endfunction

    assign len_c = (len > WMAX) ? WMAX : len;
    assign q_nxt = core_next(q, sh[0]);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (len_c != '0) ? S_RUN : S_DONE;
            S_RUN:   if (rem == ONE) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Datapath: load on accepted start, one bit per RUN cycle, hold otherwise.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sh  <= '0;
            rem <= '0;
            cnt <= '0;
            q   <= 2'b00;
`ifdef SEQ_RUNNER_HIT_EN
            idx   <= '0;
            hit_r <= 1'b0;
            fh_r  <= '0;
`endif
        end else if (state == S_IDLE && start) begin
            sh  <= pattern;
            rem <= len_c;
            cnt <= '0;
            q   <= 2'b00;
`ifdef SEQ_RUNNER_HIT_EN
            idx   <= '0;
            hit_r <= 1'b0;
            fh_r  <= '0;
`endif
        end else if (state == S_RUN) begin
            sh  <= sh >> 1;
            rem <= rem - ONE;
            q   <= q_nxt;
            if (q_nxt == 2'b11) cnt <= cnt + ONE;
`ifdef SEQ_RUNNER_HIT_EN
            idx <= idx + ONE;
            if (q_nxt == 2'b11 && !hit_r) begin
                hit_r <= 1'b1;
                fh_r  <= idx + ONE;
            end
`endif
        end
    end

    assign count   = cnt;
    assign final_q = q;
`ifdef SEQ_RUNNER_HIT_EN
    assign hit       = hit_r;
    assign first_hit = fh_r;
`endif

endmodule
